saci_cmd_arbiter: RTL and testbench
===================================

// Module: saci_cmd_arbiter
// PURPOSE
//  Shares one saci_master between N_REQ on-chip/FPGA command sources (config loader, register poller, test port).
//  Accepts one SACI command per requester via valid/ready, picks a winner round-robin, and sequences start_o/slave_mask_o/data_o.
//  Tracks the master's busy_i through the transaction and returns a per-requester done/error pulse.
//  Sits directly in front of saci_master; the arbiter is the only driver of its start/mask/data inputs.
// PARAMETERS
//  N_REQ      4     number of requesters (2..8)
//  DWIDTH     53    saci_master data width incl. start bit; payload = DWIDTH-1 bits
//  N_SLAVES   3     width of slave select mask
//  TIMEOUT    4095  max clk cycles per phase (busy rise / busy fall) before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk           in   1                  system clock, same clock as saci_master
//  rst_n         in   1                  synchronous active-low reset
//  req_valid_i   in   N_REQ              requester i has a command pending
//  req_ready_o   out  N_REQ              one-hot accept; transfer on valid&ready
//  req_data_i    in   N_REQ x (DWIDTH-1) command payload per requester (start bit excluded)
//  req_sel_i     in   N_REQ x N_SLAVES   active-high slave select per requester
//  done_o        out  N_REQ              1-cycle completion pulse to owning requester
//  err_o         out  1                  qualifies done_o: 1 = timeout abort
//  start_o       out  1                  to saci_master start_i
//  slave_mask_o  out  N_SLAVES           to saci_master slave_mask_i, active-low, '1 when idle
//  data_o        out  DWIDTH             to saci_master data_i = {1'b1, payload}
//  busy_i        in   1                  from saci_master busy_o
//  active_o      out  1                  transaction in flight (state != IDLE)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): state=IDLE, rr_ptr=0, req_ready_o=0, done_o=0, err_o=0, start_o=0,
//   slave_mask_o='1, data_o='0, timer=0. Reset mid-transaction aborts silently: no done_o pulse.
//  States: IDLE -> GRANT -> START -> WAIT_BUSY -> RUN -> DONE -> IDLE.
//  IDLE: if any req_valid_i and busy_i=0, winner = first set bit at or after rr_ptr (wrapping N_REQ-1 -> 0);
//   assert req_ready_o[winner] combinationally this cycle; latch payload, sel, owner; go GRANT. Else stay.
//   busy_i=1 in IDLE (foreign/stale transaction) blocks granting.
//  rr_ptr <= winner+1 (mod N_REQ) on grant; N_REQ=1 degenerates to fixed grant.
//  GRANT: data_o={1'b1,payload}, slave_mask_o=~sel held stable; 1 cycle setup; go START.
//  START: start_o=1 for exactly 1 cycle, mask/data held; go WAIT_BUSY, timer cleared.
//  WAIT_BUSY: mask/data held; busy_i=1 -> RUN, timer cleared; timer==TIMEOUT -> DONE with err.
//  RUN: mask/data held until busy_i=0 -> DONE (ok); timer==TIMEOUT -> DONE with err.
//  DONE: done_o[owner]=1, err_o=err flag, 1 cycle; slave_mask_o='1, data_o kept; go IDLE.
//  sel all-zero: command still issued (mask '1), completes normally; no special case.
//  Latency: accept -> start_o = 2 cycles; busy_i fall -> done_o = 1 cycle; min accept-to-accept = 5 + busy duration.
//  Simultaneous: new valids during a transaction wait; requester dropping valid before ready is legal (no grant).
//  done_o and req_ready_o never assert in the same cycle. Timer saturates, never wraps.
// STRUCTURE
//  Package saci_pkg: typedef enum logic [2:0] arb_state_t {IDLE,GRANT,START,WAIT_BUSY,RUN,DONE};
//   localparam SACI_START_BIT = 1'b1; shared SACI width constants (DWIDTH default 53).
//  Sub-module rr_arbiter (N): req vector + ptr -> one-hot grant + index; pure combinational, reusable.
//  Top: FSM, payload/owner registers, phase timer.
// TESTING
//  1 Single req0, payload 52'h0_1234_5678_9ABC, sel 3'b001 -> ready[0] 1 cycle, start_o 2 cycles later,
//    data_o=53'h1_0_1234_5678_9ABC, mask 3'b110 until busy falls, done_o[0] 1 cycle after, err_o=0.
//  2 All 4 valid held, rr_ptr=0 -> grant order 0,1,2,3,0; each done_o to matching owner, none skipped.
//  3 busy_i never rises, TIMEOUT=15 -> done_o[owner]=1 with err_o=1 at 16 cycles after WAIT_BUSY; mask back to '1.
//  4 busy_i stuck high in RUN -> err abort after TIMEOUT; busy_i=1 in IDLE holds off next grant until it drops.
//  5 rst_n low during RUN -> next cycle all outputs at reset values, no done_o; post-reset grant starts at req0.
//  6 Real saci_master + SaciSlaveWrapper, stim of 3 writes from req1/req2 -> slave sees 3 commands, 3 done_o, err_o=0.

Source files
------------

// File: rtl/saci_cmd_arbiter_pkg.sv
// Shared SACI command-arbiter types and width constants.
package saci_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT_BUSY,
    RUN,
    DONE
  } arb_state_t;

  localparam logic SACI_START_BIT = 1'b1;
  localparam int   SACI_DWIDTH    = 53;
  localparam int   SACI_N_SLAVES  = 3;
  localparam int   SACI_N_REQ     = 4;
  localparam int   SACI_TIMEOUT   = 4095;

  // Round-robin pointer advance: index after the winner, wrapping at n.
  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/saci_cmd_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
module saci_cmd_arbiter_rr #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] pos;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      pos = sum[IW-1:0];
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/saci_cmd_arbiter.sv
// Shares one saci_master between N_REQ command sources: round-robin accept,
// start/mask/data sequencing, busy tracking with per-phase timeout.
module saci_cmd_arbiter
  import saci_cmd_arbiter_pkg::*;
#(
  parameter int N_REQ    = SACI_N_REQ,
  parameter int DWIDTH   = SACI_DWIDTH,
  parameter int N_SLAVES = SACI_N_SLAVES,
  parameter int TIMEOUT  = SACI_TIMEOUT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_valid_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  input  logic [N_REQ-1:0][DWIDTH-2:0]        req_data_i,
  input  logic [N_REQ-1:0][N_SLAVES-1:0]      req_sel_i,
  output logic [N_REQ-1:0]                    done_o,
  output logic                                err_o,
  output logic                                start_o,
  output logic [N_SLAVES-1:0]                 slave_mask_o,
  output logic [DWIDTH-1:0]                   data_o,
  input  logic                                busy_i,
  output logic                                active_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  arb_state_t          state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       owner_q;
  logic [N_REQ-1:0]    done_q;
  logic                err_q;
  logic                start_q;
  logic [N_SLAVES-1:0] mask_q;
  logic [DWIDTH-1:0]   data_q;
  logic [TW-1:0]       timer_q;

  logic [N_REQ-1:0]    win_gnt;
  logic [IW-1:0]       win_idx;
  logic                win_any;
  logic                grant_ok;

  saci_cmd_arbiter_rr #(.N(N_REQ)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // A high busy_i while idle belongs to someone else's transaction; hold off.
  assign grant_ok    = (state_q == IDLE) && !busy_i && win_any;
  assign req_ready_o = grant_ok ? win_gnt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      mask_q   <= '1;
      data_q   <= '0;
      timer_q  <= '0;
    end else begin
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_ok) begin
            owner_q  <= win_idx;
            rr_ptr_q <= IW'(rr_wrap_inc(int'(win_idx), N_REQ));
            data_q   <= {SACI_START_BIT, req_data_i[win_idx]};
            mask_q   <= ~req_sel_i[win_idx];
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          timer_q <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy_i) begin
            timer_q <= '0;
            state_q <= RUN;
          end else if (timer_q == TMAX) begin
            done_q[owner_q] <= 1'b1;
            err_q           <= 1'b1;
            mask_q          <= '1;
            state_q         <= DONE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RUN: begin
          if (!busy_i || timer_q == TMAX) begin
            done_q[owner_q] <= 1'b1;
            err_q           <= busy_i;
            mask_q          <= '1;
            state_q         <= DONE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_o       = done_q;
  assign err_o        = err_q;
  assign start_o      = start_q;
  assign slave_mask_o = mask_q;
  assign data_o       = data_q;
  assign active_o     = (state_q != IDLE);

endmodule

// File: tb/tb_saci_cmd_arbiter.sv
// Directed bench for saci_cmd_arbiter: per-cycle vector table plus hand sequences.
module tb_saci_cmd_arbiter;

  localparam int N_REQ    = 4;
  localparam int DWIDTH   = 53;
  localparam int N_SLAVES = 3;
  localparam int TIMEOUT  = 15;

  logic                           clk;
  logic                           rst_n;
  logic [N_REQ-1:0]               req_valid_i;
  logic [N_REQ-1:0]               req_ready_o;
  logic [N_REQ-1:0][DWIDTH-2:0]   req_data_i;
  logic [N_REQ-1:0][N_SLAVES-1:0] req_sel_i;
  logic [N_REQ-1:0]               done_o;
  logic                           err_o;
  logic                           start_o;
  logic [N_SLAVES-1:0]            slave_mask_o;
  logic [DWIDTH-1:0]              data_o;
  logic                           busy_i;
  logic                           active_o;

  saci_cmd_arbiter #(
    .N_REQ(N_REQ), .DWIDTH(DWIDTH), .N_SLAVES(N_SLAVES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .req_sel_i    (req_sel_i),
    .done_o       (done_o),
    .err_o        (err_o),
    .start_o      (start_o),
    .slave_mask_o (slave_mask_o),
    .data_o       (data_o),
    .busy_i       (busy_i),
    .active_o     (active_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [DWIDTH-2:0] P0 = 52'h0_1234_5678_9ABC;
  localparam logic [DWIDTH-2:0] P1 = 52'hA_BCDE_F012_3456;
  localparam logic [DWIDTH-1:0] D0 = 53'h10_1234_5678_9ABC;
  localparam logic [DWIDTH-1:0] D1 = 53'h1A_BCDE_F012_3456;

  typedef struct {
    logic [3:0]  valid;
    logic        busy;
    logic [3:0]  ready;
    logic [3:0]  done;
    logic        err;
    logic        start;
    logic [2:0]  mask;
    logic [52:0] data;
    logic        active;
  } vec_t;

  vec_t tv[16];

  // scoreboard queues of expected one-hot owners
  logic [3:0] exp_q[$];
  logic [3:0] exp_done_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid_i = '0;
    busy_i      = 1'b0;
    cyc();
    cyc();
    settle();
    chk("rst_ready",  64'(req_ready_o),  64'h0);
    chk("rst_done",   64'(done_o),       64'h0);
    chk("rst_err",    64'(err_o),        64'h0);
    chk("rst_start",  64'(start_o),      64'h0);
    chk("rst_mask",   64'(slave_mask_o), 64'h7);
    chk("rst_data",   64'(data_o),       64'h0);
    chk("rst_active", 64'(active_o),     64'h0);
    rst_n = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_done"},  64'(done_o),       64'h0);
    chk({tag, "_err"},   64'(err_o),        64'h0);
    chk({tag, "_start"}, 64'(start_o),      64'h0);
    chk({tag, "_mask"},  64'(slave_mask_o), 64'h7);
    chk({tag, "_data"},  64'(data_o),       64'h0);
    chk({tag, "_active"},64'(active_o),     64'h0);
  endtask

  initial begin
    int busy_cnt;
    int grants;
    int dones;
    int cnt;
    logic overlap;

    req_data_i[0] = P0;  req_sel_i[0] = 3'b001;
    req_data_i[1] = P1;  req_sel_i[1] = 3'b011;
    req_data_i[2] = 52'h5_5555_AAAA_0F0F; req_sel_i[2] = 3'b010;
    req_data_i[3] = 52'hF_0000_1111_2222; req_sel_i[3] = 3'b111;

    //               valid   busy  ready   done    err   start mask    data   active
    tv[0]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 3'b111, 53'h0, 1'b0};
    tv[1]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b110, D0,    1'b1};
    tv[2]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b110, D0,    1'b1};
    tv[3]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b110, D0,    1'b1};
    tv[4]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b110, D0,    1'b1};
    tv[5]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b110, D0,    1'b1};
    tv[6]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b110, D0,    1'b1};
    tv[7]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b110, D0,    1'b1};
    tv[8]  = '{4'b0010, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 3'b111, D0,    1'b1};
    tv[9]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 3'b111, D0,    1'b0};
    tv[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b100, D1,    1'b1};
    tv[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'b100, D1,    1'b1};
    tv[12] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b100, D1,    1'b1};
    tv[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b100, D1,    1'b1};
    tv[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 3'b111, D1,    1'b1};
    tv[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b111, D1,    1'b0};

    do_reset();

    // single transactions from req0 then req1, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      cyc();
      req_valid_i = tv[i].valid;
      busy_i      = tv[i].busy;
      settle();
      chk($sformatf("tv%0d_ready", i),  64'(req_ready_o),  64'(tv[i].ready));
      chk($sformatf("tv%0d_done", i),   64'(done_o),       64'(tv[i].done));
      chk($sformatf("tv%0d_err", i),    64'(err_o),        64'(tv[i].err));
      chk($sformatf("tv%0d_start", i),  64'(start_o),      64'(tv[i].start));
      chk($sformatf("tv%0d_mask", i),   64'(slave_mask_o), 64'(tv[i].mask));
      chk($sformatf("tv%0d_data", i),   64'(data_o),       64'(tv[i].data));
      chk($sformatf("tv%0d_active", i), 64'(active_o),     64'(tv[i].active));
    end

    // round-robin fairness with all four requesters held valid
    do_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_done_q = {};
    busy_cnt = 0; grants = 0; dones = 0; overlap = 1'b0;
    for (int c = 0; c < 200; c++) begin
      cyc();
      busy_i = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      req_valid_i = (grants < 5) ? 4'b1111 : 4'b0000;
      settle();
      if ((req_ready_o & done_o) != 0) overlap = 1'b1;
      if (req_ready_o != 0) begin
        if (exp_q.size() > 0) begin
          exp_done_q.push_back(exp_q[0]);
          chk($sformatf("rr_grant%0d", grants), 64'(req_ready_o), 64'(exp_q.pop_front()));
        end else begin
          chk("rr_extra_grant", 64'(req_ready_o), 64'h0);
        end
        grants++;
      end
      if (done_o != 0) begin
        if (exp_done_q.size() > 0)
          chk($sformatf("rr_done%0d", dones), 64'(done_o), 64'(exp_done_q.pop_front()));
        else
          chk("rr_extra_done", 64'(done_o), 64'h0);
        chk($sformatf("rr_err%0d", dones), 64'(err_o), 64'h0);
        dones++;
      end
      if (start_o) busy_cnt = 3;
      if (dones == 5) break;
    end
    chk("rr_done_count", 64'(dones), 64'd5);
    chk("rr_overlap", 64'(overlap), 64'h0);

    // busy never rises: abort 16 cycles after entering WAIT_BUSY (rr_ptr now 1)
    cyc(); req_valid_i = 4'b1000; busy_i = 1'b0; settle();
    chk("to1_ready", 64'(req_ready_o), 64'b1000);
    cyc(); req_valid_i = 4'b0000; settle();
    cyc(); settle();
    chk("to1_start", 64'(start_o), 64'h1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(); settle();
      cnt++;
      if (cnt == 1) chk("to1_mask_wait", 64'(slave_mask_o), 64'h0);
      if (done_o != 0) break;
    end
    chk("to1_latency", 64'(cnt), 64'd17);
    chk("to1_done", 64'(done_o), 64'b1000);
    chk("to1_err", 64'(err_o), 64'h1);
    chk("to1_mask_done", 64'(slave_mask_o), 64'h7);

    // busy stuck high in RUN: abort after TIMEOUT, then foreign busy blocks grant
    cyc(); req_valid_i = 4'b0001; settle();
    chk("to2_ready", 64'(req_ready_o), 64'b0001);
    cyc(); req_valid_i = 4'b0000; settle();
    cyc(); settle();
    chk("to2_start", 64'(start_o), 64'h1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(); busy_i = 1'b1; settle();
      cnt++;
      if (done_o != 0) break;
    end
    chk("to2_latency", 64'(cnt), 64'd18);
    chk("to2_done", 64'(done_o), 64'b0001);
    chk("to2_err", 64'(err_o), 64'h1);
    for (int c = 0; c < 3; c++) begin
      cyc(); req_valid_i = 4'b0010; busy_i = 1'b1; settle();
      chk($sformatf("busy_block%0d", c), 64'(req_ready_o), 64'h0);
    end
    cyc(); busy_i = 1'b0; settle();
    chk("busy_release_ready", 64'(req_ready_o), 64'b0010);

    // reset in the middle of RUN: silent abort, arbitration restarts at req0
    cyc(); req_valid_i = 4'b0000; settle();
    cyc(); settle();
    chk("mid_start", 64'(start_o), 64'h1);
    cyc(); busy_i = 1'b1; settle();
    cyc(); settle();
    chk("mid_active", 64'(active_o), 64'h1);
    cyc(); rst_n = 1'b0; settle();
    cyc(); rst_n = 1'b1; busy_i = 1'b0; settle();
    chk("mid_ready", 64'(req_ready_o), 64'h0);
    check_outputs("mid_rst");
    cyc(); req_valid_i = 4'b1111; settle();
    chk("post_rst_ready", 64'(req_ready_o), 64'b0001);
    chk("post_rst_done", 64'(done_o), 64'h0);
    cyc(); req_valid_i = 4'b0000; settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
